// File: rtl/frame_sequencer.sv
// Write-side frame controller for a double-buffered frame buffer: optional
// solid-colour clear, renderer pass-through, then a vblank-gated buffer swap.
module frame_sequencer #(
  parameter  int FB_WIDTH  = 320,
  parameter  int FB_HEIGHT = 180,
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT,
  localparam int FB_SIZE   = $clog2(FB_PIXELS)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_start_in,
  input  logic               clear_en_in,
  input  logic [15:0]        clear_color_in,
  input  logic [FB_SIZE-1:0] rend_addr_in,
  input  logic [15:0]        rend_data_in,
  input  logic               rend_we_in,
  input  logic               render_done_in,
  input  logic               vblank_in,
  output logic [FB_SIZE-1:0] fb_write_addr_out,
  output logic [15:0]        fb_write_data_out,
  output logic               fb_write_enable_out,
  output logic               swap_buffer_out,
  output logic               render_enable_out,
  output logic               busy_out,
  output logic               overrun_out,
  output logic [15:0]        frame_count_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RENDER,
    S_WAIT_VBLANK,
    S_SWAP
  } state_e;

  localparam logic [FB_SIZE-1:0] LAST_ADDR  = FB_SIZE'(FB_PIXELS - 1);
  localparam logic [FB_SIZE:0]   PIXELS_EXT = (FB_SIZE + 1)'(FB_PIXELS);

  state_e               state_q, state_d;
  logic [FB_SIZE-1:0]   clr_addr_q, clr_addr_d;
  logic [15:0]          clear_color_q, clear_color_d;
  logic                 rend_vld_q, rend_vld_d;
  logic [FB_SIZE-1:0]   rend_addr_q, rend_addr_d;
  logic [15:0]          rend_data_q, rend_data_d;
  logic [FB_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]          wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 swap_q, swap_d;
  logic                 render_en_q, render_en_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 rend_in_range;

  assign rend_in_range = ({1'b0, rend_addr_in} < PIXELS_EXT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    clear_color_d = clear_color_q;
    rend_vld_d    = (state_q == S_RENDER) && rend_we_in && rend_in_range;
    rend_addr_d   = rend_addr_q;
    rend_data_d   = rend_data_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_count_d = frame_count_q;

    if (rend_vld_d) begin
      rend_addr_d = rend_addr_in;
      rend_data_d = rend_data_in;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          clear_color_d = clear_color_in;
          clr_addr_d    = '0;
          state_d       = clear_en_in ? S_CLEAR : S_RENDER;
        end
      end
      S_CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_addr_q;
        wr_data_d  = clear_color_q;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) state_d = S_RENDER;
      end
      S_RENDER: begin
        if (render_done_in) state_d = S_WAIT_VBLANK;
      end
      S_WAIT_VBLANK: begin
        if (vblank_in) state_d = S_SWAP;
      end
      S_SWAP: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Renderer writes lag the state by one stage, so they can never collide with clear writes.
    if (rend_vld_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rend_addr_q;
      wr_data_d = rend_data_q;
    end

    swap_d      = (state_q == S_SWAP);
    render_en_d = (state_q == S_RENDER);
    busy_d      = (state_q != S_IDLE);
    overrun_d   = frame_start_in && (state_q != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      clr_addr_q    <= '0;
      clear_color_q <= '0;
      rend_vld_q    <= 1'b0;
      rend_addr_q   <= '0;
      rend_data_q   <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      swap_q        <= 1'b0;
      render_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      clear_color_q <= clear_color_d;
      rend_vld_q    <= rend_vld_d;
      rend_addr_q   <= rend_addr_d;
      rend_data_q   <= rend_data_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
      swap_q        <= swap_d;
      render_en_q   <= render_en_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign fb_write_addr_out   = wr_addr_q;
  assign fb_write_data_out   = wr_data_q;
  assign fb_write_enable_out = wr_en_q;
  assign swap_buffer_out     = swap_q;
  assign render_enable_out   = render_en_q;
  assign busy_out            = busy_q;
  assign overrun_out         = overrun_q;
  assign frame_count_out     = frame_count_q;

endmodule
